// File: rtl/whack_pkg.sv
// Shared types and elaboration helpers for the whack-a-mole game FSM.
package whack_pkg;

  localparam int MAX_LEDS = 64;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SHOW,
    HIT,
    MISS,
    GAME_OVER
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int window_ms, input int gap_ms);
    return $clog2(max_int(window_ms, gap_ms) + 1);
  endfunction

  // Indices past the last LED fold back once by NUM_LEDS, so a wide LFSR index still lands on a lamp.
  function automatic logic [MAX_LEDS-1:0] idx_to_onehot(input int unsigned idx, input int unsigned n);
    int unsigned red;
    red = (idx >= n) ? idx - n : idx;
    return MAX_LEDS'(1) << red;
  endfunction

endpackage

// File: rtl/whack_a_mole_fsm_if.sv
// Player-facing signal bundle: tick/button/switch/LFSR inputs and LED/score/display outputs.
interface whack_a_mole_fsm_if #(
  parameter int NUM_LEDS = 18,
  parameter int SCORE_W  = 8,
  parameter int LIVES    = 3
);
  localparam int IDX_W   = $clog2(NUM_LEDS);
  localparam int LIVES_W = $clog2(LIVES + 1);

  logic                tick_ms;
  logic                start_btn;
  logic [NUM_LEDS-1:0] switches;
  logic [IDX_W-1:0]    rand_idx;
  logic [NUM_LEDS-1:0] led_on;
  logic [SCORE_W-1:0]  score;
  logic [LIVES_W-1:0]  lives;
  logic                hit_pulse;
  logic                miss_pulse;
  logic                game_over;
  logic [SCORE_W-1:0]  high_score;

  modport master (
    output tick_ms, start_btn, switches, rand_idx,
    input  led_on, score, lives, hit_pulse, miss_pulse, game_over, high_score
  );

  modport slave (
    input  tick_ms, start_btn, switches, rand_idx,
    output led_on, score, lives, hit_pulse, miss_pulse, game_over, high_score
  );

endinterface

// File: rtl/rise_edge_detect.sv
// Single-cycle rising-edge detector for an already-debounced level.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_in,
  output logic o_edge
);

  logic r_prev;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_in;
  end

  assign o_edge = i_in & ~r_prev;

endmodule

// File: rtl/whack_a_mole_fsm.sv
// Whack-a-mole game controller: targets, scoring, lives and a shrinking response window.
// Define WHACK_HIGH_SCORE_EN to keep a best-score register across games.
module whack_a_mole_fsm
  import whack_pkg::*;
#(
  parameter int NUM_LEDS      = 18,
  parameter int WINDOW_MS     = 1000,
  parameter int MIN_WINDOW_MS = 250,
  parameter int SPEEDUP_MS    = 50,
  parameter int GAP_MS        = 300,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 8
) (
  input logic clk,
  input logic rst_n,
  whack_a_mole_fsm_if.slave bus
);

  localparam int CNT_W   = cnt_width(WINDOW_MS, GAP_MS);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam logic [CNT_W-1:0]   WIN_INIT  = CNT_W'(WINDOW_MS);
  localparam logic [CNT_W-1:0]   WIN_MIN   = CNT_W'(MIN_WINDOW_MS);
  localparam logic [CNT_W-1:0]   WIN_STEP  = CNT_W'(SPEEDUP_MS);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_MS - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam int unsigned        SHRINK_FLOOR = MIN_WINDOW_MS + SPEEDUP_MS;

  if (GAP_MS == 0 || WINDOW_MS < MIN_WINDOW_MS || NUM_LEDS > MAX_LEDS) begin : g_bad_params
    $error("whack_a_mole_fsm: illegal timing or LED-count parameters");
  end

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, r_window;
  logic [SCORE_W-1:0]   r_score;
  logic [LIVES_W-1:0]   r_lives;
  logic [NUM_LEDS-1:0]  r_target, r_snap;
  logic [NUM_LEDS-1:0]  w_diff, w_target_next;
  logic                 w_start;

  rise_edge_detect u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_in  (bus.start_btn),
    .o_edge(w_start)
  );

  assign w_diff        = bus.switches ^ r_snap;
  assign w_target_next = NUM_LEDS'(idx_to_onehot(32'(bus.rand_idx), NUM_LEDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: the default assignment first guarantees every path drives w_state_next, so no latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_start) w_state_next = ARM;
      ARM:       if (bus.tick_ms && r_cnt == GAP_LAST) w_state_next = SHOW;
      SHOW: begin
        // Hit beats a wrong switch, which beats a timeout landing in the same cycle.
        if (w_diff == r_target)                                    w_state_next = HIT;
        else if (w_diff != '0)                                     w_state_next = MISS;
        else if (bus.tick_ms && r_cnt == r_window - CNT_W'(1))     w_state_next = MISS;
      end
      HIT:       w_state_next = ARM;
      MISS:      w_state_next = (r_lives == LIVES_W'(1)) ? GAME_OVER : ARM;
      GAME_OVER: if (w_start) w_state_next = ARM;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_window <= WIN_INIT;
      r_score  <= '0;
      r_lives  <= LIVES_INIT;
      r_target <= '0;
      r_snap   <= '0;
    end else begin
      if (w_state_next != r_state)
        r_cnt <= '0;
      else if (bus.tick_ms && (r_state == ARM || r_state == SHOW))
        r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        IDLE, GAME_OVER: begin
          if (w_start) begin
            r_score  <= '0;
            r_lives  <= LIVES_INIT;
            r_window <= WIN_INIT;
          end
        end
        ARM: begin
          if (w_state_next == SHOW) begin
            r_target <= w_target_next;
            r_snap   <= bus.switches;
          end
        end
        HIT: begin
          if (r_score != '1) r_score <= r_score + SCORE_W'(1);
          r_window <= (32'(r_window) >= SHRINK_FLOOR) ? r_window - WIN_STEP : WIN_MIN;
        end
        MISS:    r_lives <= r_lives - LIVES_W'(1);
        default: ;
      endcase
    end
  end

`ifdef WHACK_HIGH_SCORE_EN
  logic [SCORE_W-1:0] r_high_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_high_score <= '0;
    else if (r_state == MISS && w_state_next == GAME_OVER && r_score > r_high_score)
      r_high_score <= r_score;
  end

  assign bus.high_score = r_high_score;
`else
  assign bus.high_score = '0;
`endif

  assign bus.led_on     = (r_state == SHOW) ? r_target : '0;
  assign bus.score      = r_score;
  assign bus.lives      = r_lives;
  assign bus.hit_pulse  = (r_state == HIT);
  assign bus.miss_pulse = (r_state == MISS);
  assign bus.game_over  = (r_state == GAME_OVER);

endmodule

// File: tb/tb_whack_a_mole_fsm.sv
// Scoreboard bench for whack_a_mole_fsm: directed game rounds, monitor checks every hit/miss.
module tb_whack_a_mole_fsm;

  localparam int NUM_LEDS      = 8;
  localparam int WINDOW_MS     = 10;
  localparam int MIN_WINDOW_MS = 6;
  localparam int SPEEDUP_MS    = 2;
  localparam int GAP_MS        = 3;
  localparam int LIVES         = 3;
  localparam int SCORE_W       = 2;
`ifdef WHACK_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  typedef struct {
    bit is_hit;
    int score;
    int lives;
    bit go;
    int ticks;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   show_ticks = 0;
  bit   pulse_seen = 1'b0;
  logic [NUM_LEDS-1:0] sw = '0;
  exp_t sb_q[$];

  whack_a_mole_fsm_if #(.NUM_LEDS(NUM_LEDS), .SCORE_W(SCORE_W), .LIVES(LIVES)) bus ();

  whack_a_mole_fsm #(
    .NUM_LEDS(NUM_LEDS), .WINDOW_MS(WINDOW_MS), .MIN_WINDOW_MS(MIN_WINDOW_MS),
    .SPEEDUP_MS(SPEEDUP_MS), .GAP_MS(GAP_MS), .LIVES(LIVES), .SCORE_W(SCORE_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic do_tick();
    @(posedge clk); #1 bus.tick_ms = 1'b1;
    show_ticks++;
    @(posedge clk); #1 bus.tick_ms = 1'b0;
  endtask

  task automatic press_start();
    @(posedge clk); #1 bus.start_btn = 1'b1;
    @(posedge clk); #1 bus.start_btn = 1'b0;
  endtask

  task automatic flip(input logic [NUM_LEDS-1:0] mask);
    @(posedge clk); #1;
    sw = sw ^ mask;
    bus.switches = sw;
  endtask

  task automatic run_arm(input int idx);
    bus.rand_idx = 3'(idx);
    repeat (GAP_MS - 1) begin
      do_tick();
      @(posedge clk);
    end
    @(negedge clk);
    check("arm_dark", 32'(bus.led_on), 32'h0);
    do_tick();
    @(negedge clk);
    check("show_led", 32'(bus.led_on), 32'(1) << idx);
    show_ticks = 0;
  endtask

  task automatic expect_evt(input bit is_hit, input int score, input int lives, input bit go, input int ticks);
    exp_t e;
    e.is_hit = is_hit;
    e.score  = score;
    e.lives  = lives;
    e.go     = go;
    e.ticks  = ticks;
    pulse_seen = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic wait_evt(input string name);
    for (int n = 0; n < 30 && !pulse_seen; n++) @(posedge clk);
    check({name, "_seen"}, 32'(pulse_seen), 32'h1);
  endtask

  task automatic hit_round(input int idx, input int score, input int lives);
    run_arm(idx);
    expect_evt(1'b1, score, lives, 1'b0, -1);
    flip(NUM_LEDS'(1) << idx);
    wait_evt("hit");
  endtask

  task automatic timeout_round(input int idx, input int score, input int lives, input bit go, input int ticks);
    run_arm(idx);
    expect_evt(1'b0, score, lives, go, ticks);
    for (int n = 0; n < WINDOW_MS + 4 && !pulse_seen; n++) begin
      do_tick();
      repeat (2) @(posedge clk);
    end
    check("timeout_seen", 32'(pulse_seen), 32'h1);
  endtask

  // Monitor: pops one expectation per hit/miss pulse, then checks the settled state a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.hit_pulse || bus.miss_pulse)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", 32'({bus.hit_pulse, bus.miss_pulse}), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", 32'({bus.hit_pulse, bus.miss_pulse}), e.is_hit ? 32'h2 : 32'h1);
          if (e.ticks >= 0) check("timeout_tick", 32'(show_ticks), 32'(e.ticks));
          @(negedge clk);
          check("pulse_width", 32'({bus.hit_pulse, bus.miss_pulse}), 32'h0);
          check("score", 32'(bus.score), 32'(e.score));
          check("lives", 32'(bus.lives), 32'(e.lives));
          check("game_over", 32'(bus.game_over), 32'(e.go));
          check("led_after", 32'(bus.led_on), 32'h0);
          pulse_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick_ms   = 1'b0;
    bus.start_btn = 1'b0;
    bus.switches  = '0;
    bus.rand_idx  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(bus.led_on), 32'h0);
    check("rst_score", 32'(bus.score), 32'h0);
    check("rst_lives", 32'(bus.lives), 32'h3);
    check("rst_go", 32'(bus.game_over), 32'h0);
    check("rst_pulses", 32'({bus.hit_pulse, bus.miss_pulse}), 32'h0);
    check("rst_hs", 32'(bus.high_score), 32'h0);
    rst_n = 1'b1;

    // Game 1: timeout at the full window, a hit, a wrong switch, then two switches at once.
    press_start();
    timeout_round(5, 0, 2, 1'b0, 10);
    hit_round(5, 1, 2);
    run_arm(5);
    expect_evt(1'b0, 1, 1, 1'b0, -1);
    flip(8'h04);
    wait_evt("wrong_sw");
    run_arm(5);
    expect_evt(1'b0, 1, 0, 1'b1, -1);
    flip(8'h24);
    wait_evt("multi_sw");
    do_tick();
    do_tick();
    @(negedge clk);
    check("go_hold", 32'(bus.game_over), 32'h1);
    check("go_score_hold", 32'(bus.score), 32'h1);
    check("go_led", 32'(bus.led_on), 32'h0);
    check("hs_game1", 32'(bus.high_score), HS_EN ? 32'h1 : 32'h0);

    // Game 2: window shrinks 10->8->6->6; score saturates at 3 with a 2-bit counter.
    press_start();
    @(negedge clk);
    check("restart_lives", 32'(bus.lives), 32'h3);
    check("restart_score", 32'(bus.score), 32'h0);
    check("restart_go", 32'(bus.game_over), 32'h0);
    run_arm(0);
    press_start();
    @(negedge clk);
    check("start_ignored", 32'(bus.led_on), 32'h1);
    expect_evt(1'b1, 1, 3, 1'b0, -1);
    flip(8'h01);
    wait_evt("hit_after_start");
    timeout_round(1, 1, 2, 1'b0, 8);
    hit_round(7, 2, 2);
    hit_round(6, 3, 2);
    hit_round(3, 3, 2);
    timeout_round(4, 3, 1, 1'b0, 6);
    timeout_round(4, 3, 0, 1'b1, 6);
    @(negedge clk);
    check("hs_game2", 32'(bus.high_score), HS_EN ? 32'h3 : 32'h0);

    // Game 3: three consecutive timeouts; a lower score leaves the best score alone.
    press_start();
    timeout_round(2, 0, 2, 1'b0, 10);
    timeout_round(2, 0, 1, 1'b0, 10);
    timeout_round(2, 0, 0, 1'b1, 10);
    @(negedge clk);
    check("hs_game3", 32'(bus.high_score), HS_EN ? 32'h3 : 32'h0);

    // Game 4: asynchronous reset in the middle of SHOW.
    press_start();
    run_arm(3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_led", 32'(bus.led_on), 32'h0);
    check("arst_score", 32'(bus.score), 32'h0);
    check("arst_lives", 32'(bus.lives), 32'h3);
    check("arst_go", 32'(bus.game_over), 32'h0);
    check("arst_hs", 32'(bus.high_score), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (GAP_MS + 1) do_tick();
    @(negedge clk);
    check("idle_after_rst", 32'(bus.led_on), 32'h0);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/whack_a_mole_fsm.md
Name: whack_a_mole_fsm

Overview:
- Parametrised successor to the single-target reaction-game FSM.
- Runs a complete game: light one random LED, wait for the player to flip the matching switch, score hits, count misses against a life budget, shrink the response window after each hit, and end in GAME_OVER.
- Owns its own millisecond counters, driven by an external 1 ms tick, and its own button edge detection.
- Sits between the switch/button/LFSR inputs and the LED and 7-segment display drivers.

Parameters:
- NUM_LEDS, 18, number of target LEDs and switches.
- WINDOW_MS, 1000, initial response window in ms.
- MIN_WINDOW_MS, 250, floor on the response window.
- SPEEDUP_MS, 50, window reduction applied per hit.
- GAP_MS, 300, dark interval between targets in ms.
- LIVES, 3, misses allowed per game.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tick_ms  in  1  single-cycle pulse, once per ms.
- start_btn  in  1  level from the debounced start button.
- switches  in  NUM_LEDS  player switches.
- rand_idx  in  $clog2(NUM_LEDS)  pseudo-random index from the LFSR.
- led_on  out  NUM_LEDS  target LED drive.
- score  out  SCORE_W  current score.
- lives  out  $clog2(LIVES+1)  remaining lives.
- hit_pulse  out  1  one cycle per hit.
- miss_pulse  out  1  one cycle per miss.
- game_over  out  1  high while in GAME_OVER.
- high_score  out  SCORE_W  best score; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, score=0, lives=LIVES, window_cur=WINDOW_MS.
  - led_on=0, pulses=0, game_over=0, high_score=0, tick counter=0, edge register=0.
- start edge: start_btn high while its registered copy is low. One-cycle latency.
- Tick counter:
  - Cleared on every state entry.
  - Incremented on each tick_ms while in ARM or SHOW.
  - Width $clog2(max(WINDOW_MS,GAP_MS)+1).
- States and transitions:
  - IDLE: on start edge, load score=0, lives=LIVES, window_cur=WINDOW_MS, then go to ARM.
  - ARM: led_on=0. When a tick arrives with cnt==GAP_MS-1:
    - register target = one-hot(rand_idx), reduced so that rand_idx>=NUM_LEDS maps to rand_idx-NUM_LEDS;
    - snapshot switches into snap;
    - go to SHOW.
  - SHOW: led_on=target. diff = switches ^ snap, evaluated every cycle.
    - diff==target: go to HIT.
    - diff!=0 and diff!=target (wrong switch, or extra switches): go to MISS.
    - Otherwise, a tick with cnt==window_cur-1: go to MISS (timeout).
    - Priority: hit > wrong switch > timeout, when they occur in the same cycle.
  - HIT (one cycle):
    - hit_pulse=1;
    - score += 1, saturating at 2^SCORE_W-1;
    - window_cur = max(window_cur-SPEEDUP_MS, MIN_WINDOW_MS), computed without underflow;
    - go to ARM.
  - MISS (one cycle):
    - miss_pulse=1, lives -= 1;
    - if lives was 1, go to GAME_OVER, otherwise go to ARM.
  - GAME_OVER: game_over=1, led_on=0, score held. A start edge goes to IDLE-equivalent init and then ARM; a new game starts directly.
- A start edge during ARM/SHOW/HIT/MISS is ignored.
- All outputs are driven from registers or from the state register only. There is no combinational path from switches or tick_ms to any output.
- Switch toggles during ARM are ignored; the snapshot is taken at the ARM→SHOW edge.
- GAP_MS=0 or WINDOW_MS<MIN_WINDOW_MS are illegal; guard with an elaboration-time assertion.

Optional Feature:
- Macro: WHACK_HIGH_SCORE_EN.
- Defined:
  - high_score register is updated on entry to GAME_OVER if score>high_score;
  - it survives new games and is cleared only by rst_n.
- Undefined: high_score is tied to 0 and no register is inferred.

Decomposition:
- Package whack_pkg holds:
  - state_t enum {IDLE, ARM, SHOW, HIT, MISS, GAME_OVER};
  - function idx_to_onehot(idx, n) with the reduction rule;
  - localparam width helpers.
- One sub-module, rise_edge_detect (clk, rst_n, in, edge), used for start_btn.
- Counters and datapath stay in the top module.

Test Plan:
All scenarios use NUM_LEDS=8, WINDOW_MS=10, MIN_WINDOW_MS=6, SPEEDUP_MS=2, GAP_MS=3, LIVES=3.
- Start edge in IDLE with rand_idx=5 → after 3 ticks led_on=8'h20. Toggle sw[5] → hit_pulse for 1 cycle, score=1, window_cur=8, led_on=0 on the next cycle.
- SHOW with no switch activity → miss_pulse on the 10th tick, lives 3→2, back to ARM.
- SHOW with target=5, toggle sw[2] → immediate MISS, lives decremented. Toggle sw[5] and sw[2] in the same cycle → MISS.
- Three consecutive timeouts → game_over=1, lives=0, led_on=0. A start edge → lives=3, score=0, ARM.
- Three hits → window_cur sequence 8, 6, 6 (floor). Score with SCORE_W=2 saturates at 3 after the 4th hit.
- Assert rst_n low mid-SHOW asynchronously → all outputs reset within the same cycle, state=IDLE. With WHACK_HIGH_SCORE_EN: game ending at score 4 then score 2 → high_score=4.
